// File: rtl/memory_stage.sv
// memory_stage
// MEM-stage data-memory access unit sitting directly in front of the MEM/WB
// register. It issues one request per load/store on a req/ready data bus,
// holds the pipeline frozen while the access is in flight, and presents the
// extended load result in the cycle the pipeline is released.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   RegWriteMI          RegWrite from the EX/MEM register
//   MemReadM/MemWriteM  load / store in MEM (both set = store)
//   funct3M             000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM          byte address
//   WriteDataM          store data (low bits significant)
//   dmem_req/we/addr/be/wdata   data-memory request side
//   dmem_rdata/ready            data-memory response side
//   RegWriteM           RegWriteMI gated by stall and fault
//   ReadDataM           extended load data to MEM/WB
//   StallM              freeze PC/IF/ID/EX/MEM registers
//   FaultM              misaligned, illegal funct3 or timeout
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteMI,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        RegWriteM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             fault_q, fault_d;

    logic             access;
    logic             is_store;
    logic             bad;
    logic [1:0]       off;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ext_data;

    assign access   = MemReadM | MemWriteM;
    assign is_store = MemWriteM;
    assign off      = ALUResultM[1:0];

    // Illegal encodings, misalignment, and unsigned-store encodings all fault
    // before any bus traffic is generated.
    always_comb begin
        bad = 1'b0;
        case (funct3M)
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            3'b001, 3'b101:         bad = off[0];
            3'b010:                 bad = (off != 2'b00);
            default:                bad = 1'b0;
        endcase
        if (is_store && funct3M[2]) begin
            bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (access && !bad) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    rdata_d = dmem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                fault_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load lane extraction; address/funct3 are still valid in DONE because
    // the EX/MEM register is held until the release edge.
    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3M)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'd0, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            3'b010:  ext_data = rdata_q;
            default: ext_data = '0;
        endcase
    end

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
        if (is_store) begin
            case (funct3M[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    dmem_be    = off[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = WriteDataM;
                end
            endcase
        end
    end

    assign dmem_we   = is_store;
    assign dmem_addr = {ALUResultM[31:2], 2'b00};

    always_comb begin
        dmem_req  = 1'b0;
        StallM    = 1'b0;
        FaultM    = 1'b0;
        ReadDataM = '0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (bad) begin
                        FaultM = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        StallM   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                StallM   = 1'b1;
            end
            S_DONE: begin
                FaultM    = fault_q;
                ReadDataM = fault_q ? 32'd0 : ext_data;
            end
            default: ;
        endcase
        // The state register clears asynchronously, but IDLE alone would
        // still request on a legal access, so reset masks the strobe too.
        if (rst) begin
            dmem_req = 1'b0;
        end
    end

    assign RegWriteM = RegWriteMI & ~StallM & ~FaultM;

endmodule
